serial_adder_ctrl: RTL and testbench

//  Bit-serial WIDTH-bit adder built around the existing one-bit full_adder cell.
//  - Upstream of full_adder: feeds it one operand bit pair plus the registered carry per clock.
//  - Downstream of full_adder: collects S into a result shift register and latches Cout as the next carry.
//  - Low-area add path for multi-cycle datapath ops; results are handed off with a START/DONE handshake.

---
 rtl/serial_adder_ctrl_pkg.sv | 13 +
 rtl/serial_adder_ctrl_if.sv | 26 ++
 rtl/serial_adder_ctrl_full_adder.sv | 16 +
 rtl/serial_adder_ctrl.sv | 134 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

  // Controller states; the unused encoding 2'd3 decodes back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester and the serial adder.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = serial_adder_ctrl_pkg::DEFAULT_WIDTH
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic             OVF;

  // Requester side: drives operands and START, observes status/result.
  modport master (
    output START, A, B, CIN,
    input  BUSY, DONE, SUM, COUT, OVF
  );

  // Adder side: consumes the request, produces status/result.
  modport slave (
    input  START, A, B, CIN,
    output BUSY, DONE, SUM, COUT, OVF
  );
endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell used by the serial adder.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  // Pure combinational sum and carry.
  always_comb begin
    S    = A ^ B ^ Cin;
    Cout = (A & B) | (Cin & (A ^ B));
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder evaluation per clock, LSB first,
// with a START/BUSY/DONE handshake and registered SUM/COUT/OVF results.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                CLK,
  input  logic                RST,
  serial_adder_ctrl_if.slave  bus
);

  localparam int unsigned     CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_MSB  = CW'(WIDTH - 2);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load;
  logic             fa_s;
  logic             fa_cout;

  full_adder u_fa (
    .A    (sa_q[0]),
    .B    (sb_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  // State and datapath registers; reset discards any in-flight add.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, shift/accumulate and status decode.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: load = bus.START;

      ST_RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_MSB) begin
          cmsb_d = fa_cout;
        end
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          ovf_d   = fa_cout ^ cmsb_q;
          state_d = ST_FIN;
        end
      end

      // The edge leaving FIN is the first edge a new request can be taken,
      // giving one add per WIDTH+1 cycles when START is held.
      ST_FIN: begin
        state_d = ST_IDLE;
        load    = bus.START;
      end

      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      sa_d    = bus.A;
      sb_d    = bus.B;
      carry_d = bus.CIN;
      cnt_d   = '0;
      state_d = ST_RUN;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.SUM  = sum_q;
  assign bus.COUT = cout_q;
  assign bus.OVF  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed testbench for serial_adder_ctrl (WIDTH=8, 20 ns clock).
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic CLK = 1'b0;
  logic RST;
  int   checks   = 0;
  int   failures = 0;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #10 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge CLK);
    bus.START = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.CIN   = cin;
    @(negedge CLK);
    bus.START = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    bus.CIN   = ~cin;
  endtask

  // Count edges until DONE is seen (bounded).
  task automatic wait_done(output int lat);
    int n = 0;
    while (bus.DONE !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    lat = n;
  endtask

  task automatic add_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [7:0] es, input logic ec,
                           input logic eo);
    int lat;
    issue(a, b, cin);
    wait_done(lat);
    chk({tag, "_lat"}, lat, W);
    chk({tag, "_sum"}, bus.SUM, es);
    chk({tag, "_cout"}, bus.COUT, ec);
    chk({tag, "_ovf"}, bus.OVF, eo);
    @(negedge CLK);
    chk({tag, "_done_drop"}, bus.DONE, 1'b0);
    chk({tag, "_idle"}, bus.BUSY, 1'b0);
  endtask

  initial begin
    int busy_n;
    int done_n;
    int lat;
    logic [7:0] sum_cap;
    logic       cout_cap;
    logic       ovf_cap;

    RST       = 1'b1;
    bus.START = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.CIN   = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    chk("rst_busy", bus.BUSY, 1'b0);
    chk("rst_done", bus.DONE, 1'b0);
    chk("rst_sum", bus.SUM, 8'h00);
    chk("rst_cout", bus.COUT, 1'b0);
    chk("rst_ovf", bus.OVF, 1'b0);

    // Basic add, then results hold through IDLE while inputs change.
    add_check("add_3c_05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
    bus.A = 8'h99;
    bus.B = 8'h77;
    repeat (5) @(negedge CLK);
    chk("hold_sum", bus.SUM, 8'h41);
    chk("hold_busy", bus.BUSY, 1'b0);

    // Carry ripples through every bit; BUSY window measured.
    issue(8'hFF, 8'h00, 1'b1);
    busy_n  = 0;
    done_n  = 0;
    sum_cap = '0;
    cout_cap = 1'b0;
    ovf_cap = 1'b0;
    repeat (14) begin
      if (bus.BUSY === 1'b1) busy_n++;
      if (bus.DONE === 1'b1) begin
        done_n++;
        sum_cap  = bus.SUM;
        cout_cap = bus.COUT;
        ovf_cap  = bus.OVF;
      end
      @(negedge CLK);
    end
    chk("ff_busy_cycles", busy_n, 9);
    chk("ff_done_pulses", done_n, 1);
    chk("ff_sum", sum_cap, 8'h00);
    chk("ff_cout", cout_cap, 1'b1);
    chk("ff_ovf", ovf_cap, 1'b0);

    // START while BUSY is neither taken nor queued.
    issue(8'h01, 8'h01, 1'b0);
    repeat (2) @(negedge CLK);
    bus.START = 1'b1;
    bus.A     = 8'h11;
    @(negedge CLK);
    bus.START = 1'b0;
    done_n  = 0;
    sum_cap = '0;
    repeat (16) begin
      if (bus.DONE === 1'b1) begin
        done_n++;
        sum_cap = bus.SUM;
      end
      @(negedge CLK);
    end
    chk("ign_done_pulses", done_n, 1);
    chk("ign_sum", sum_cap, 8'h02);
    chk("ign_idle", bus.BUSY, 1'b0);

    // Signed overflow cases.
    add_check("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    add_check("ovf_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    add_check("ovf_80_ff", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);

    // Reset at cnt==4 discards the add and clears results.
    issue(8'hAA, 8'h55, 1'b0);
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("midrst_busy", bus.BUSY, 1'b0);
    chk("midrst_done", bus.DONE, 1'b0);
    chk("midrst_sum", bus.SUM, 8'h00);
    chk("midrst_cout", bus.COUT, 1'b0);
    chk("midrst_ovf", bus.OVF, 1'b0);
    done_n = 0;
    repeat (15) begin
      if (bus.DONE === 1'b1) done_n++;
      @(negedge CLK);
    end
    chk("midrst_no_done", done_n, 0);
    add_check("post_rst", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);

    // START held: back-to-back adds, DONE every 9 cycles.
    @(negedge CLK);
    bus.START = 1'b1;
    bus.A     = 8'h12;
    bus.B     = 8'h34;
    bus.CIN   = 1'b0;
    @(negedge CLK);
    bus.A   = 8'hF0;
    bus.B   = 8'h20;
    bus.CIN = 1'b1;
    wait_done(lat);
    chk("b2b0_lat", lat, W);
    chk("b2b0_sum", bus.SUM, 8'h46);
    chk("b2b0_cout", bus.COUT, 1'b0);
    @(negedge CLK);
    bus.A   = 8'h40;
    bus.B   = 8'h40;
    bus.CIN = 1'b0;
    chk("b2b1_busy", bus.BUSY, 1'b1);
    wait_done(lat);
    chk("b2b1_period", lat + 1, 9);
    chk("b2b1_sum", bus.SUM, 8'h11);
    chk("b2b1_cout", bus.COUT, 1'b1);
    chk("b2b1_ovf", bus.OVF, 1'b0);
    @(negedge CLK);
    bus.START = 1'b0;
    bus.A     = 8'h00;
    bus.B     = 8'h00;
    wait_done(lat);
    chk("b2b2_period", lat + 1, 9);
    chk("b2b2_sum", bus.SUM, 8'h80);
    chk("b2b2_cout", bus.COUT, 1'b0);
    chk("b2b2_ovf", bus.OVF, 1'b1);
    @(negedge CLK);
    chk("b2b_end_idle", bus.BUSY, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
